// File: rtl/ysyx_25040105_ifetch.sv
// Instruction-fetch controller: owns the PC, issues one fetch at a time over valid/ready,
// and hands fetched words to the datapath; redirects kill stale in-flight fetches.
module ysyx_25040105_ifetch #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        o_imem_req_valid,
  input  logic        i_imem_req_ready,
  output logic [31:0] o_imem_req_addr,
  input  logic        i_imem_rsp_valid,
  output logic        o_imem_rsp_ready,
  input  logic [31:0] i_imem_rsp_data,
  output logic        o_inst_valid,
  input  logic        i_inst_ready,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc,
  input  logic        i_redirect_en,
  input  logic [31:0] i_redirect_addr,
  output logic [31:0] o_fetch_cnt
);

  typedef enum logic [1:0] {StReq, StWait, StHold} state_e;

  state_e      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_inst;
  logic        r_kill;
  logic [31:0] r_redir_pc;
  logic [31:0] r_fetch_cnt;

  assign o_imem_req_valid = (r_state == StReq) && !rst;
  assign o_imem_rsp_ready = (r_state == StWait);
  assign o_inst_valid     = (r_state == StHold);
  assign o_imem_req_addr  = r_pc;
  assign o_pc             = r_pc;
  assign o_inst           = r_inst;
  assign o_fetch_cnt      = r_fetch_cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StReq;
      r_pc        <= RESET_PC;
      r_inst      <= '0;
      r_kill      <= 1'b0;
      r_redir_pc  <= '0;
      r_fetch_cnt <= '0;
    end else begin
      unique case (r_state)
        StReq: begin
          // The request address stays put; the redirect only marks this fetch for discard.
          if (i_redirect_en) begin
            r_kill     <= 1'b1;
            r_redir_pc <= i_redirect_addr;
          end
          if (i_imem_req_ready) r_state <= StWait;
        end
        StWait: begin
          if (i_imem_rsp_valid) begin
            r_kill <= 1'b0;
            if (i_redirect_en) begin
              r_pc    <= i_redirect_addr;
              r_state <= StReq;
            end else if (r_kill) begin
              r_pc    <= r_redir_pc;
              r_state <= StReq;
            end else begin
              r_inst  <= i_imem_rsp_data;
              r_state <= StHold;
            end
          end else if (i_redirect_en) begin
            r_kill     <= 1'b1;
            r_redir_pc <= i_redirect_addr;
          end
        end
        StHold: begin
          if (i_inst_ready) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
            r_pc        <= i_redirect_en ? i_redirect_addr : r_pc + 32'd4;
            r_state     <= StReq;
          end else if (i_redirect_en) begin
            r_pc    <= i_redirect_addr;
            r_state <= StReq;
          end
        end
        default: r_state <= StReq;
      endcase
    end
  end

endmodule
